im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Program loader and write-side initiator for the 16-word instruction memory.
- Receives a byte stream over a valid/ready handshake: a one-byte length header, then little-endian 32-bit instruction words.
- Assembles each word and drives the memory write port (write enable, word-aligned address, data) one word per write cycle.
- Sits between the host/debug byte link and the instruction memory; the CPU fetch path reads what it writes.

Parameters:
- WORDS, 16, instruction-memory depth in words; legal header range is 1..WORDS.
- ADDR_W, 4, word-index width; ADDR_W = log2(WORDS); drives address bits [ADDR_W+1:2].

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load session from IDLE, DONE or ERROR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- im_mem_write  out  1  write strobe to the instruction memory.
- im_addr  out  32  byte address = {zeros, word_idx, 2'b00}.
- im_data  out  32  assembled instruction word.
- busy  out  1  session in progress (RECV_LEN, RECV, WRITE, CHK).
- done  out  1  session completed cleanly; held until the next start.
- err  out  1  header or checksum error; held until the next start.
- words_written  out  ADDR_W+1  count of words committed this session.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, all counters 0.
- Reset mid-session aborts at that edge with no further writes; the memory is re-initialised by the same reset.
- Handshake: a byte transfers only on a posedge with byte_valid=1 and byte_ready=1.
- byte_ready=1 only in RECV_LEN, RECV and CHK.
- State IDLE: waits for start; start -> RECV_LEN; clears done, err, words_written, word_idx and byte_idx.
- State RECV_LEN: accepted byte N.
  - N=0 or N>WORDS -> ERROR.
  - Otherwise latch N -> RECV.
- State RECV: accepted byte k (k=0..3) goes to im_data[8k+7:8k]; byte_idx increments mod 4; the fourth byte -> WRITE.
- State WRITE (exactly one cycle):
  - im_mem_write=1; im_addr and im_data stable the whole cycle, so the memory's negedge capture is safe.
  - At the end of the cycle: word_idx+1, words_written+1.
  - If words_written+1 == N -> CHK (or DONE if the checksum feature is compiled out); else -> RECV.
- im_mem_write is 0 in every state except WRITE.
- State DONE: done=1; start -> RECV_LEN (new session).
- State ERROR: err=1; no writes issued; start -> RECV_LEN.
- Latency: the write strobe asserts the cycle after the 4th byte of a word is accepted; back-to-back words take 5 cycles minimum.
- start while busy is ignored.
- Words beyond N are never requested; upstream bytes stay pending.
- word_idx never wraps: N<=WORDS guarantees max index WORDS-1.
- im_data holds the last word after WRITE; bytes of the next word overwrite lanes in order.

Optional Feature:
- Macro: IM_LOADER_CHECKSUM_EN.
- With the macro:
  - A running XOR of all payload bytes (header excluded) is kept.
  - After the N-th WRITE, state CHK accepts one byte.
  - Byte equal to the XOR -> DONE; mismatch -> ERROR.
  - Words already written remain in memory.
- Without the macro: no CHK state; the N-th WRITE goes directly to DONE.

Decomposition:
- Shared package holds:
  - state enum: IDLE, RECV_LEN, RECV, WRITE, CHK, DONE, ERROR;
  - IM_WORDS=16;
  - IM_ADDR_W=4;
  - the byte-lane ordering constant (little-endian).
- One natural sub-module: im_loader_word_asm. It holds the byte-lane shift/assembly, byte_idx, and the XOR accumulator. The top level keeps the FSM and address counter.

Test Plan:
- Header 0x02, bytes 05 00 FE 00, 05 20 F8 00 -> two single-cycle strobes:
  - addr 0x0 data 0x00FE0005;
  - addr 0x4 data 0x00F82005;
  - then done=1, words_written=2.
- Header 0x00 -> ERROR, err=1, no im_mem_write.
- Header 0x11 -> ERROR, err=1, no im_mem_write.
- Header 0x10, 64 bytes with byte_valid toggled every other cycle -> 16 strobes at addr 0x00..0x3C, no extra acceptance, done=1.
- reset asserted after the 2nd byte of word 1 -> next cycle all outputs 0, state IDLE, no strobe.
- start pulsed during RECV -> ignored, session completes normally.
- With IM_LOADER_CHECKSUM_EN, header 0x01, bytes 11 22 33 44:
  - checksum byte 0x44 -> done=1;
  - checksum byte 0x45 -> err=1, word 0x44332211 still written at addr 0x0.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, memory geometry and byte-lane ordering.
package im_loader_pkg;

    localparam int IM_WORDS  = 16;
    localparam int IM_ADDR_W = 4;

    // Stream bytes fill the word starting at the least significant lane.
    localparam logic LANE_LITTLE_ENDIAN = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RECV_LEN,
        RECV,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    function automatic logic [1:0] laneOf(input logic [1:0] byteIdx);
        return LANE_LITTLE_ENDIAN ? byteIdx : ~byteIdx;
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// The master side is the loader; the slave side is the link/memory environment.
interface im_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_mem_write;
    logic [31:0] im_addr;
    logic [31:0] im_data;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_mem_write,
        output im_addr,
        output im_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_mem_write,
        input  im_addr,
        input  im_data
    );

endinterface

// File: rtl/im_loader_word_asm.sv
// Assembles stream bytes into 32-bit words and tracks the byte position.
// With IM_LOADER_CHECKSUM_EN it also keeps a running XOR of payload bytes.
module im_loader_word_asm
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_data,
    output logic        o_lastByte
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]  o_xor
`endif
);

    logic [31:0] r_data;
    logic [1:0]  r_byteIdx;
    logic [4:0]  w_lane;

    assign w_lane     = {laneOf(r_byteIdx), 3'b000};
    assign o_data     = r_data;
    assign o_lastByte = (r_byteIdx == 2'd3);

    // The word register is never cleared on a new session, so it keeps showing the last committed word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_byteIdx <= '0;
        end else if (i_clear) begin
            r_byteIdx <= '0;
        end else if (i_accept) begin
            r_data[w_lane +: 8] <= i_byte;
            r_byteIdx           <= r_byteIdx + 2'd1;
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    assign o_xor = r_xor;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xor <= '0;
        end else if (i_clear) begin
            r_xor <= '0;
        end else if (i_accept) begin
            r_xor <= r_xor ^ i_byte;
        end
    end
`endif

endmodule

// File: rtl/im_loader.sv
// Program loader: length header + little-endian words in, one memory write per word out.
// Optional trailing checksum byte when IM_LOADER_CHECKSUM_EN is defined.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int WORDS  = IM_WORDS,
    parameter int ADDR_W = IM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    im_loader_if.master       bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [7:0] WORDS_B = 8'(WORDS);

    state_t            r_state;
    logic              r_byteReady;
    logic              r_memWrite;
    logic [ADDR_W-1:0] r_wordIdx;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wordsWritten;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_payloadAccept;
    logic              w_sessionStart;
    logic              w_headerOk;
    logic              w_lastByte;
    logic [ADDR_W:0]   w_wordsNext;
    logic [31:0]       w_data;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]        w_xor;
`endif

    assign w_accept        = bus.byte_valid && r_byteReady;
    assign w_payloadAccept = w_accept && (r_state == RECV);
    assign w_sessionStart  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_headerOk      = (bus.byte_data != 8'd0) && (bus.byte_data <= WORDS_B);
    assign w_wordsNext     = r_wordsWritten + 1'b1;

    im_loader_word_asm u_wordAsm (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_sessionStart),
        .i_accept   (w_payloadAccept),
        .i_byte     (bus.byte_data),
        .o_data     (w_data),
        .o_lastByte (w_lastByte)
`ifdef IM_LOADER_CHECKSUM_EN
        ,
        .o_xor      (w_xor)
`endif
    );

    // Every output is a register updated alongside the state, so ready/strobe never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_byteReady    <= 1'b0;
            r_memWrite     <= 1'b0;
            r_wordIdx      <= '0;
            r_len          <= '0;
            r_wordsWritten <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                RECV_LEN: begin
                    if (w_accept) begin
                        if (w_headerOk) begin
                            r_len   <= bus.byte_data[ADDR_W:0];
                            r_state <= RECV;
                        end else begin
                            r_state     <= ERROR;
                            r_byteReady <= 1'b0;
                            r_busy      <= 1'b0;
                            r_err       <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (w_accept && w_lastByte) begin
                        r_state     <= WRITE;
                        r_byteReady <= 1'b0;
                        r_memWrite  <= 1'b1;
                    end
                end
                WRITE: begin
                    r_memWrite     <= 1'b0;
                    r_wordsWritten <= w_wordsNext;
                    if (w_wordsNext == r_len) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        r_state     <= CHK;
                        r_byteReady <= 1'b1;
`else
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
`endif
                    end else begin
                        // The index only advances when another word follows, so it cannot wrap.
                        r_state     <= RECV;
                        r_byteReady <= 1'b1;
                        r_wordIdx   <= r_wordIdx + 1'b1;
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_accept) begin
                        r_byteReady <= 1'b0;
                        r_busy      <= 1'b0;
                        if (bus.byte_data == w_xor) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        r_state        <= RECV_LEN;
                        r_byteReady    <= 1'b1;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_err          <= 1'b0;
                        r_wordsWritten <= '0;
                        r_wordIdx      <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_byteReady <= 1'b0;
                    r_memWrite  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready   = r_byteReady;
    assign bus.im_mem_write = r_memWrite;
    assign bus.im_addr      = {{(30-ADDR_W){1'b0}}, r_wordIdx, 2'b00};
    assign bus.im_data      = w_data;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;
    assign words_written    = r_wordsWritten;

endmodule

// File: tb/tb_im_loader.sv
// Directed-vector bench for im_loader; checksum scenarios run when IM_LOADER_CHECKSUM_EN is defined.
// A negedge monitor logs every write strobe and every accepted byte.
module tb_im_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] wordsWritten;

    im_loader_if bus();

    im_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (wordsWritten)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    int          strobeCount;
    int          acceptCount;
    logic [31:0] logAddr [0:31];
    logic [31:0] logData [0:31];
    logic [7:0]  tbXor;

    // Strobes are logged mid-cycle; a strobe lasting two cycles would be logged twice.
    always @(negedge clk) begin
        if (bus.im_mem_write === 1'b1) begin
            if (strobeCount < 32) begin
                logAddr[strobeCount] = bus.im_addr;
                logData[strobeCount] = bus.im_data;
            end
            strobeCount = strobeCount + 1;
        end
        if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
            acceptCount = acceptCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        strobeCount = 0;
        acceptCount = 0;
        for (int i = 0; i < 32; i++) begin
            logAddr[i] = 32'hDEAD_DEAD;
            logData[i] = 32'hDEAD_DEAD;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beginSession();
        tbXor = 8'h00;
        pulseStart();
    endtask

    // Presents one byte and holds it until the loader takes it, then idles gap cycles.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            tick();
        end else begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        bus.byte_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic applyPayload(input logic [7:0] b, input int gap);
        tbXor = tbXor ^ b;
        applyStimulus(b, gap);
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        applyPayload(w[7:0], gap);
        applyPayload(w[15:8], gap);
        applyPayload(w[23:16], gap);
        applyPayload(w[31:24], gap);
    endtask

    task automatic finishSession();
`ifdef IM_LOADER_CHECKSUM_EN
        applyStimulus(tbXor, 0);
`endif
    endtask

    task automatic waitEnd();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("session_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        checkOutput({tag, "_wr"},    32'(bus.im_mem_write), 32'd0);
        checkOutput({tag, "_addr"},  bus.im_addr, 32'd0);
        checkOutput({tag, "_data"},  bus.im_data, 32'd0);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_done"},  32'(done), 32'd0);
        checkOutput({tag, "_err"},   32'(err), 32'd0);
        checkOutput({tag, "_words"}, 32'(wordsWritten), 32'd0);
    endtask

    function automatic logic [31:0] patWord(input int i);
        logic [31:0] k;
        k = 32'(i);
        return 32'h1357_9BDF ^ (k * 32'h0101_0101);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        clearLog();
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // Two-word load with write-latency checks on each strobe.
        clearLog();
        beginSession();
        checkOutput("t1_busy", 32'(busy), 32'd1);
        applyStimulus(8'h02, 0);
        sendWord(32'h00FE_0005, 0);
        checkOutput("t1_w0_latency", 32'(bus.im_mem_write), 32'd1);
        checkOutput("t1_w0_data_now", bus.im_data, 32'h00FE_0005);
        sendWord(32'h00F8_2005, 0);
        checkOutput("t1_w1_latency", 32'(bus.im_mem_write), 32'd1);
        checkOutput("t1_w1_addr_now", bus.im_addr, 32'h0000_0004);
        finishSession();
        waitEnd();
        checkOutput("t1_strobes", 32'(strobeCount), 32'd2);
        checkOutput("t1_addr0", logAddr[0], 32'h0000_0000);
        checkOutput("t1_data0", logData[0], 32'h00FE_0005);
        checkOutput("t1_addr1", logAddr[1], 32'h0000_0004);
        checkOutput("t1_data1", logData[1], 32'h00F8_2005);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_err", 32'(err), 32'd0);
        checkOutput("t1_busy_end", 32'(busy), 32'd0);
        checkOutput("t1_words", 32'(wordsWritten), 32'd2);
        checkOutput("t1_hold_data", bus.im_data, 32'h00F8_2005);

        // Header 0 and header 17 both land in ERROR without writing.
        for (int h = 0; h < 2; h++) begin
            logic [7:0] hdr;
            hdr = (h == 0) ? 8'h00 : 8'h11;
            clearLog();
            beginSession();
            applyStimulus(hdr, 0);
            checkOutput("hdr_err", 32'(err), 32'd1);
            checkOutput("hdr_done", 32'(done), 32'd0);
            checkOutput("hdr_busy", 32'(busy), 32'd0);
            checkOutput("hdr_ready", 32'(bus.byte_ready), 32'd0);
            repeat (4) tick();
            checkOutput("hdr_strobes", 32'(strobeCount), 32'd0);
            checkOutput("hdr_words", 32'(wordsWritten), 32'd0);
        end

        // Full 16-word load with byte_valid toggling every other cycle.
        clearLog();
        beginSession();
        checkOutput("t4_err_cleared", 32'(err), 32'd0);
        applyStimulus(8'h10, 1);
        for (int i = 0; i < 16; i++) sendWord(patWord(i), 1);
        finishSession();
        waitEnd();
        checkOutput("t4_strobes", 32'(strobeCount), 32'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("t4_addr%0d", i), logAddr[i], 32'(i * 4));
            checkOutput($sformatf("t4_data%0d", i), logData[i], patWord(i));
        end
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_words", 32'(wordsWritten), 32'd16);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        repeat (5) tick();
`ifdef IM_LOADER_CHECKSUM_EN
        checkOutput("t4_accepts", 32'(acceptCount), 32'd66);
`else
        checkOutput("t4_accepts", 32'(acceptCount), 32'd65);
`endif
        checkOutput("t4_ready_after", 32'(bus.byte_ready), 32'd0);
        checkOutput("t4_strobes_after", 32'(strobeCount), 32'd16);
        bus.byte_valid = 1'b0;

        // Reset lands after the second byte of word 1.
        clearLog();
        beginSession();
        applyStimulus(8'h02, 0);
        sendWord(32'h8765_4321, 0);
        applyPayload(8'hAB, 0);
        applyPayload(8'hCD, 0);
        reset = 1'b1;
        tick();
        checkAllZero("t5");
        repeat (3) tick();
        checkOutput("t5_strobes", 32'(strobeCount), 32'd1);
        reset = 1'b0;
        tick();

        // A start pulse mid-word is ignored.
        clearLog();
        beginSession();
        applyStimulus(8'h01, 0);
        applyPayload(8'h0D, 0);
        applyPayload(8'hF0, 0);
        pulseStart();
        applyPayload(8'hFE, 0);
        applyPayload(8'hCA, 0);
        finishSession();
        waitEnd();
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_err", 32'(err), 32'd0);
        checkOutput("t6_words", 32'(wordsWritten), 32'd1);
        checkOutput("t6_strobes", 32'(strobeCount), 32'd1);
        checkOutput("t6_addr0", logAddr[0], 32'h0000_0000);
        checkOutput("t6_data0", logData[0], 32'hCAFE_F00D);

`ifdef IM_LOADER_CHECKSUM_EN
        // Checksum byte 0x44 is correct for payload 11 22 33 44; 0x45 is not.
        for (int t = 0; t < 2; t++) begin
            clearLog();
            beginSession();
            applyStimulus(8'h01, 0);
            sendWord(32'h4433_2211, 0);
            applyStimulus((t == 0) ? 8'h44 : 8'h45, 0);
            waitEnd();
            checkOutput("t7_done", 32'(done), (t == 0) ? 32'd1 : 32'd0);
            checkOutput("t7_err", 32'(err), (t == 0) ? 32'd0 : 32'd1);
            checkOutput("t7_strobes", 32'(strobeCount), 32'd1);
            checkOutput("t7_addr0", logAddr[0], 32'h0000_0000);
            checkOutput("t7_data0", logData[0], 32'h4433_2211);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
